mfm_decoder: RTL and testbench
==============================

Name: mfm_decoder

Overview:
- Downstream of the MFM digital PLL. Runs in the clk_50 domain.
- Takes raw MFM pulses plus the PLL's recovered clk_5 and samples one MFM cell per clk_5 edge (either polarity).
- Hunts for the A1 address mark (missing-clock pattern 16'h4489), then deserialises data bits into bytes.
- Flags MFM coding violations and drops sync on error so the disk controller sees framed bytes only.

Parameters:
SYNC_PATTERN, 16'h4489, 16-cell address-mark pattern (clock/data interleaved, MSB oldest)
MAX_ZERO_RUN, 3, longest legal run of consecutive 0 cells while synced

Ports:
clk_50  in  1  50 MHz system clock
reset  in  1  synchronous active-high reset
raw_mfm  in  1  raw MFM pulse stream (same signal feeding the DPLL)
clk_5  in  1  recovered 5 MHz clock from DPLL; each edge ends one cell
rearm  in  1  one-cycle pulse: abandon sync, return to HUNT
data_byte  out  8  decoded byte, MSB first on disk
byte_valid  out  1  one-cycle pulse, data_byte/mark valid
mark  out  1  high with byte_valid when the byte is an address mark
synced  out  1  high while in SYNCED state
decode_err  out  1  one-cycle pulse on MFM violation while synced

Behaviour:
- Reset (sync, active-high): state=HUNT; shift register, pulse latch, zero-run count and cell counter cleared. clk_5_d=0, raw_mfm_d=0. All outputs 0.
  - If clk_5=1 at reset release, the first sampled "edge" shifts a 0 cell. This is harmless in HUNT.
- Pulse capture: rising edge = raw_mfm & ~raw_mfm_d. It sets pulse_seen.
- Cell end = clk_5 != clk_5_d. At cell end:
  - cell = pulse_seen | rising edge in the same cycle (a coincident pulse belongs to the ending cell).
  - Shift cell into 16-bit sr (sr[0] newest).
  - Clear pulse_seen.
  - Multiple pulses in one cell count as one.
- Data bits sit at even sr positions: data = {sr[14],sr[12],sr[10],sr[8],sr[6],sr[4],sr[2],sr[0]}. 16'h4489 decodes to 8'hA1.
- FSM HUNT:
  - On each cell end, compare the new sr to SYNC_PATTERN.
  - On match → SYNCED, cell counter=0, and next cycle emit byte_valid=1, mark=1, data_byte=8'hA1.
  - No error checking in HUNT.
- FSM SYNCED:
  - Cell counter increments per cell end, mod 16.
  - When the counter wraps (16th cell), next cycle emit byte_valid=1, mark=0, data_byte=decoded sr.
  - If sr==SYNC_PATTERN at any cell end: realign. Counter=0, emit mark byte A1. Mark takes precedence over a coincident normal byte; only one byte_valid is emitted.
  - Violation checks at each cell end:
    - new cell=1 while previous cell=1, or
    - zero-run counter > MAX_ZERO_RUN.
  - On violation: decode_err pulse next cycle, → HUNT, no byte_valid for the partial byte.
  - If a violation and a sync match coincide, the sync match wins.
- rearm: → HUNT, counter and zero-run cleared; sr retained. rearm has priority over all same-cycle events. reset has priority over rearm.
- Latency: byte_valid and decode_err are registered, asserted exactly 1 clk_50 after the cell-end cycle. data_byte holds until the next byte_valid.
- synced = (state==SYNCED), registered, updating on the same cycle as the state change.
- Zero-run counter: 3 bits, saturating, reset on any 1 cell.

Decomposition:
- Shared package mfm_pkg holds:
  - state enum {HUNT, SYNCED}
  - MFM_A1_SYNC = 16'h4489
  - MFM_A1_BYTE = 8'hA1
  - MFM_MAX_ZERO_RUN = 3
- One sub-module, mfm_cell_sampler: edge detection of raw_mfm/clk_5, pulse latch, emitting cell_valid/cell_bit. The FSM, shift register and checks stay in mfm_decoder.

Test Plan:
- Reset then encoded cells 0x4489 → 1 cycle after the final cell edge: byte_valid=1, mark=1, data_byte=A1, synced=1.
- A1 followed by encoded bytes FE,00,FF (correct clocks) → three byte_valid pulses with mark=0, data 8'hFE, 8'h00, 8'hFF, each 16 cells apart.
- Synced, inject two consecutive 1 cells → decode_err pulse 1 cycle later, synced=0, no byte_valid for that byte; a later 0x4489 re-syncs.
- Synced, drop pulses giving 4 zero cells → decode_err, HUNT. Zero-run counts of exactly 3 within A1 and data 8'h00 never flag.
- Raw pulse coincident with clk_5 edge → counted in the ending cell (A1 still detected). Three back-to-back A1 marks → three mark=1 bytes.
- rearm mid-byte and reset mid-byte → no byte_valid, synced=0 next cycle. Reset clears all outputs on the following edge.

Source files
------------

// File: rtl/mfm_pkg.sv
// Shared types and constants for the MFM address-mark decoder.
// Holds the FSM state type, the A1 address-mark constants and a helper
// that pulls the eight data cells out of a 16-cell window.
package mfm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        SYNCED = 1'b1
    } mfm_state_e;

    localparam logic [15:0] MFM_A1_SYNC      = 16'h4489;
    localparam logic [7:0]  MFM_A1_BYTE      = 8'hA1;
    localparam int unsigned MFM_MAX_ZERO_RUN = 3;

    // Data cells sit at the even positions of the window (clock cells are odd).
    function automatic logic [7:0] mfm_data_bits(input logic [15:0] sr);
        return {sr[14], sr[12], sr[10], sr[8], sr[6], sr[4], sr[2], sr[0]};
    endfunction

endpackage

// File: rtl/mfm_cell_sampler.sv
// Turns the raw MFM pulse stream into one bit per cell.
// A cell ends on every edge of the recovered clk_5; the cell is a 1 if a
// rising edge of raw_mfm was seen during the cell, including a rising edge
// that lands in the very cycle the cell ends.
// Ports:
//   clk_50     in   system clock
//   reset      in   synchronous active-high reset
//   raw_mfm    in   raw MFM pulse stream
//   clk_5      in   recovered cell clock, either edge ends a cell
//   cell_valid out  high in the cycle a cell ends (combinational)
//   cell_bit   out  value of the ending cell, valid with cell_valid
module mfm_cell_sampler (
    input  logic clk_50,
    input  logic reset,
    input  logic raw_mfm,
    input  logic clk_5,
    output logic cell_valid,
    output logic cell_bit
);

    logic clk_5_q;
    logic raw_mfm_q;
    logic pulse_seen_q;
    logic rise;

    assign rise       = raw_mfm & ~raw_mfm_q;
    assign cell_valid = clk_5 ^ clk_5_q;
    assign cell_bit   = pulse_seen_q | rise;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            clk_5_q      <= 1'b0;
            raw_mfm_q    <= 1'b0;
            pulse_seen_q <= 1'b0;
        end else begin
            clk_5_q   <= clk_5;
            raw_mfm_q <= raw_mfm;
            // A coincident pulse was already folded into cell_bit, so the
            // latch starts clean for the new cell.
            if (cell_valid) begin
                pulse_seen_q <= 1'b0;
            end else if (rise) begin
                pulse_seen_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mfm_decoder.sv
// MFM decoder: hunts for the A1 address mark, then frames the cell stream
// into bytes and drops sync on any coding violation.
//   state  | meaning
//   HUNT   | looking for SYNC_PATTERN, no error checking
//   SYNCED | framing bytes every 16 cells, checking MFM rules
// Ports:
//   clk_50     in   system clock
//   reset      in   synchronous active-high reset
//   raw_mfm    in   raw MFM pulse stream
//   clk_5      in   recovered cell clock from the DPLL
//   rearm      in   one-cycle pulse, abandon sync and hunt again
//   data_byte  out  decoded byte, held until the next byte_valid
//   byte_valid out  one-cycle pulse with each framed byte
//   mark       out  high with byte_valid when the byte is an address mark
//   synced     out  high while in SYNCED
//   decode_err out  one-cycle pulse on a violation while synced
module mfm_decoder
    import mfm_pkg::*;
#(
    parameter logic [15:0] SYNC_PATTERN = MFM_A1_SYNC,
    parameter int unsigned MAX_ZERO_RUN = MFM_MAX_ZERO_RUN
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       raw_mfm,
    input  logic       clk_5,
    input  logic       rearm,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       mark,
    output logic       synced,
    output logic       decode_err
);

    localparam logic [2:0] ZERO_LIMIT = 3'(MAX_ZERO_RUN);

    logic       cell_valid;
    logic       cell_bit;

    mfm_state_e state_q;
    logic [15:0] sr_q, sr_d;
    logic [3:0]  cnt_q;
    logic [2:0]  zrun_q, zrun_d;
    logic [7:0]  data_byte_q;
    logic        byte_valid_q, mark_q, synced_q, decode_err_q;
    logic        sync_hit;
    logic        violation;

    mfm_cell_sampler u_sampler (
        .clk_50     (clk_50),
        .reset      (reset),
        .raw_mfm    (raw_mfm),
        .clk_5      (clk_5),
        .cell_valid (cell_valid),
        .cell_bit   (cell_bit)
    );

    always_comb begin
        sr_d      = {sr_q[14:0], cell_bit};
        zrun_d    = cell_bit ? 3'd0 : ((zrun_q == 3'd7) ? zrun_q : zrun_q + 3'd1);
        sync_hit  = (sr_d == SYNC_PATTERN);
        // sr_q[0] is the previous cell.
        violation = (cell_bit & sr_q[0]) | (zrun_d > ZERO_LIMIT);
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q      <= HUNT;
            sr_q         <= '0;
            cnt_q        <= '0;
            zrun_q       <= '0;
            data_byte_q  <= '0;
            byte_valid_q <= 1'b0;
            mark_q       <= 1'b0;
            synced_q     <= 1'b0;
            decode_err_q <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            mark_q       <= 1'b0;
            decode_err_q <= 1'b0;
            if (rearm) begin
                // The window is kept; only framing state is dropped.
                state_q  <= HUNT;
                synced_q <= 1'b0;
                cnt_q    <= '0;
                zrun_q   <= '0;
            end else if (cell_valid) begin
                sr_q   <= sr_d;
                zrun_q <= zrun_d;
                if (sync_hit) begin
                    // Realign; beats a coincident byte boundary or violation.
                    state_q      <= SYNCED;
                    synced_q     <= 1'b1;
                    cnt_q        <= '0;
                    byte_valid_q <= 1'b1;
                    mark_q       <= 1'b1;
                    data_byte_q  <= MFM_A1_BYTE;
                end else if (state_q == SYNCED) begin
                    if (violation) begin
                        state_q      <= HUNT;
                        synced_q     <= 1'b0;
                        cnt_q        <= '0;
                        decode_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            byte_valid_q <= 1'b1;
                            data_byte_q  <= mfm_data_bits(sr_d);
                        end
                    end
                end
            end
        end
    end

    assign data_byte  = data_byte_q;
    assign byte_valid = byte_valid_q;
    assign mark       = mark_q;
    assign synced     = synced_q;
    assign decode_err = decode_err_q;

endmodule

// File: tb/tb_mfm_decoder.sv
module tb_mfm_decoder;

    localparam int K_NONE = 0;
    localparam int K_MARK = 1;
    localparam int K_DATA = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic       raw_mfm = 1'b0;
    logic       clk_5 = 1'b0;
    logic       rearm = 1'b0;
    logic [7:0] data_byte;
    logic       byte_valid;
    logic       mark;
    logic       synced;
    logic       decode_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t mon_e;
    int   mon_kind;
    logic prev_d = 1'b0;

    mfm_decoder dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .raw_mfm    (raw_mfm),
        .clk_5      (clk_5),
        .rearm      (rearm),
        .data_byte  (data_byte),
        .byte_valid (byte_valid),
        .mark       (mark),
        .synced     (synced),
        .decode_err (decode_err)
    );

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc++;

    // Scoreboard side: every output event must match the head of the queue.
    always @(negedge clk_50) begin
        if (byte_valid === 1'b1 || decode_err === 1'b1) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_event observed bv=%0b err=%0b data=%0h expected none", byte_valid, decode_err, data_byte);
            end
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                mon_kind = decode_err ? (byte_valid ? 4 : K_ERR) : (mark ? K_MARK : K_DATA);
                checks++;
                assert (mon_kind === mon_e.kind) else begin
                    errors++;
                    $error("FAIL event_kind observed=%0d expected=%0d", mon_kind, mon_e.kind);
                end
                checks++;
                assert (cyc === mon_e.cyc) else begin
                    errors++;
                    $error("FAIL event_cycle observed=%0d expected=%0d", cyc, mon_e.cyc);
                end
                if (mon_e.kind != K_ERR) begin
                    checks++;
                    assert (data_byte === mon_e.data) else begin
                        errors++;
                        $error("FAIL event_data observed=%0h expected=%0h", data_byte, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mfm_enc(input logic [7:0] b, input logic prev);
        logic        p;
        logic [15:0] w;
        p = prev;
        for (int i = 7; i >= 0; i--) begin
            w[2*i+1] = ~(p | b[i]);
            w[2*i]   = b[i];
            p        = b[i];
        end
        return w;
    endfunction

    // One cell = 5 clk_50 cycles; clk_5 toggles at the end of the cell.
    task automatic send_cell(input logic b, input bit coinc, input int kind, input logic [7:0] data);
        exp_t e;
        @(negedge clk_50) raw_mfm = 1'b0;
        @(negedge clk_50) if (!coinc) raw_mfm = b;
        @(negedge clk_50) raw_mfm = 1'b0;
        @(negedge clk_50);
        @(negedge clk_50);
        clk_5 = ~clk_5;
        if (coinc && b) raw_mfm = 1'b1;
        if (kind != K_NONE) begin
            e.cyc  = cyc + 1;
            e.kind = kind;
            e.data = data;
            q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input bit coinc, input int kind, input logic [7:0] data);
        for (int i = 15; i >= 0; i--)
            send_cell(w[i], coinc, (i == 0) ? kind : K_NONE, data);
    endtask

    task automatic send_mark(input bit coinc);
        send_word(16'h4489, coinc, K_MARK, 8'hA1);
        prev_d = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_word(mfm_enc(b, prev_d), 1'b0, K_DATA, b);
        prev_d = b[0];
    endtask

    task automatic flush();
        for (int i = 0; i < 16; i++) send_cell(1'b0, 1'b0, K_NONE, 8'h00);
    endtask

    initial begin
        logic [15:0] w;

        // Reset state
        repeat (3) @(negedge clk_50);
        check("rst_data_byte", data_byte, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_mark", mark, 0);
        check("rst_synced", synced, 0);
        check("rst_decode_err", decode_err, 0);
        reset = 1'b0;

        // Mark then FE, 00, FF
        send_mark(1'b0);
        @(negedge clk_50) check("synced_after_mark", synced, 1);
        send_byte(8'hFE);
        send_byte(8'h00);
        send_byte(8'hFF);
        @(negedge clk_50) check("synced_after_bytes", synced, 1);

        // Two consecutive 1 cells (FF ended on a 1)
        send_cell(1'b1, 1'b0, K_ERR, 8'h00);
        @(negedge clk_50) check("synced_after_11", synced, 0);
        flush();
        send_mark(1'b0);
        @(negedge clk_50) check("resync_after_11", synced, 1);
        send_byte(8'h00);

        // Zero run: three zeros are legal, the fourth flags
        send_mark(1'b0);
        send_cell(1'b0, 1'b0, K_NONE, 8'h00);
        send_cell(1'b0, 1'b0, K_NONE, 8'h00);
        send_cell(1'b0, 1'b0, K_NONE, 8'h00);
        @(negedge clk_50) check("synced_after_3zero", synced, 1);
        send_cell(1'b0, 1'b0, K_ERR, 8'h00);
        @(negedge clk_50) check("synced_after_4zero", synced, 0);

        // Coincident pulses, then back-to-back marks (mark beats byte wrap)
        flush();
        send_mark(1'b1);
        @(negedge clk_50) check("synced_coinc_mark", synced, 1);
        send_mark(1'b0);
        send_mark(1'b1);
        send_byte(8'h5A);

        // rearm mid-byte
        w = mfm_enc(8'h3C, prev_d);
        for (int i = 15; i >= 8; i--) send_cell(w[i], 1'b0, K_NONE, 8'h00);
        @(negedge clk_50) rearm = 1'b1;
        @(negedge clk_50) rearm = 1'b0;
        check("synced_after_rearm", synced, 0);
        for (int i = 7; i >= 0; i--) send_cell(w[i], 1'b0, K_NONE, 8'h00);
        flush();

        // reset mid-byte
        send_mark(1'b0);
        w = mfm_enc(8'h96, prev_d);
        for (int i = 15; i >= 8; i--) send_cell(w[i], 1'b0, K_NONE, 8'h00);
        @(negedge clk_50) reset = 1'b1;
        @(negedge clk_50) reset = 1'b0;
        check("midrst_data_byte", data_byte, 0);
        check("midrst_byte_valid", byte_valid, 0);
        check("midrst_mark", mark, 0);
        check("midrst_synced", synced, 0);
        check("midrst_decode_err", decode_err, 0);
        for (int i = 7; i >= 0; i--) send_cell(w[i], 1'b0, K_NONE, 8'h00);

        // Recovery after reset
        flush();
        send_mark(1'b0);
        send_byte(8'hC3);
        @(negedge clk_50) check("synced_final", synced, 1);

        repeat (10) @(negedge clk_50);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
